parking_lot_ctrl: RTL and testbench
===================================

Name: parking_lot_ctrl

Overview:
Multi-lane parking-lot controller. Each lane has two beam sensors: a (outer) and b (inner). A per-lane FSM decodes direction from the sensor sequence and emits one-cycle entry or exit events. A shared occupancy counter turns these events into a saturating car count with full/empty status and error pulses; it feeds the lot display and the gate logic.

Parameters:
N_LANES, 2, number of independent gate lanes (1..8)
CAPACITY, 100, maximum occupancy; count saturates here
TIMEOUT_CYC, 1000000, cycles a lane may stay mid-sequence before abort; 0 disables timeout
CNT_W, $clog2(CAPACITY+1), width of count (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
a  in  N_LANES  outer sensor per lane, 1 = beam blocked; synchronised upstream
b  in  N_LANES  inner sensor per lane, 1 = beam blocked; synchronised upstream
clr  in  1  synchronous clear of count to 0; reset has priority over clr
enter  out  N_LANES  one-cycle pulse per completed entry per lane
exit  out  N_LANES  one-cycle pulse per completed exit per lane
seq_err  out  N_LANES  one-cycle pulse on an illegal transition or a timeout in that lane
count  out  CNT_W  current occupancy
full  out  1  count == CAPACITY
empty  out  1  count == 0
over_err  out  1  one-cycle pulse when entries are lost to saturation at CAPACITY
under_err  out  1  one-cycle pulse when exits are lost to saturation at 0

Behaviour:
- Single clock domain. reset is asynchronous and active-high. All outputs are registered.
- Reset values: all FSMs in IDLE; enter=exit=seq_err=0; count=0; empty=1; full=0; over_err=under_err=0.
- Lane FSM has 7 states: IDLE, E1, E2, E3, X1, X2, X3. Sensor code is {a,b}.
- Entry path: IDLE -(10)-> E1 -(11)-> E2 -(01)-> E3 -(00)-> IDLE, with the enter pulse.
- Exit path: IDLE -(01)-> X1 -(11)-> X2 -(10)-> X3 -(00)-> IDLE, with the exit pulse.
- An unchanged code holds the current state.
- Reversal (the code of the previous step) moves back one state, e.g. E2 on 10 -> E1, E1 on 00 -> IDLE. No pulse.
- Any other code is illegal: go to IDLE and pulse seq_err. Examples: IDLE on 11; E1 on 01; E2 on 00 (two bits changed).
- enter/exit/seq_err assert in the cycle after the sampling edge that caused the transition, for exactly one cycle.
- Timeout: a per-lane counter runs while the lane is outside IDLE and reloads on every state change. If it reaches TIMEOUT_CYC, the lane goes to IDLE and seq_err pulses.
- A lane in IDLE that sees a non-00 illegal code (11) pulses seq_err once, then stays in IDLE until it sees 00, 10 or 01. Holding 11 does not re-pulse.
- Counter: each cycle, count_next = count + popcount(enter) - popcount(exit), computed signed at CNT_W+4 bits.
  - Result clamped to [0, CAPACITY].
  - Clamping above pulses over_err; clamping below pulses under_err.
  - Simultaneous enters and exits on different lanes net out before clamping.
- Counter latency: count reflects an enter/exit pulse one cycle after that pulse.
- full and empty are decoded from the registered count, with no extra latency.
- clr forces count=0 in the next cycle, ignoring events that cycle. The lane FSMs are unaffected.
- Reset asserted mid-sequence aborts every lane with no pulses.

Decomposition:
- Shared package parking_pkg holds:
  - the lane state encoding (3-bit localparams ST_IDLE..ST_X3);
  - sensor code constants (C_NONE=00, C_OUT=10, C_BOTH=11, C_IN=01);
  - a popcount function.
- Sub-module parking_lane_fsm: one lane FSM plus its timeout counter. Ports are clk, reset, a, b, enter, exit, seq_err; parameter TIMEOUT_CYC. It is instantiated N_LANES times with a generate loop.
- Top level parking_lot_ctrl holds the occupancy counter and the flags.

Test Plan:
- Lane 0 codes 00,10,11,01,00, one cycle each -> enter[0]=1 for one cycle, count 0->1, empty 1->0.
- Lane 1 codes 00,01,11,10,00 with count=1 -> exit[1] pulse, count=0, empty=1, no under_err.
- Lane 0 codes 10,11,10,00 (car backs out) -> no enter, no seq_err, count unchanged.
- Lane 0 at IDLE sees 11 -> single seq_err[0] pulse; then a valid entry -> enter[0].
- TIMEOUT_CYC=8, lane held at 10 for 8 cycles -> seq_err[0] pulses, FSM IDLE; following 00 -> no pulse.
- CAPACITY=3, count=3, lane 0 entry and lane 1 entry in the same cycle -> count stays 3, full=1, over_err pulse. Same cycle as one entry plus one exit -> count 3, no over_err. Async reset mid-sequence -> count=0 immediately.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared lane-state encoding, sensor codes and a small popcount helper
// for the parking-lot controller.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_E1   = 3'd1,
        ST_E2   = 3'd2,
        ST_E3   = 3'd3,
        ST_X1   = 3'd4,
        ST_X2   = 3'd5,
        ST_X3   = 3'd6
    } lane_state_e;

    // Sensor code is {a, b}: a = outer beam, b = inner beam.
    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_OUT  = 2'b10;
    localparam logic [1:0] C_BOTH = 2'b11;
    localparam logic [1:0] C_IN   = 2'b01;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// One gate lane: decodes entry/exit direction from the {a,b} beam sequence
// and aborts a sequence that stalls for TIMEOUT_CYC cycles.
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit,
    output logic seq_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    lane_state_e   state, state_nxt;
    logic          lock, lock_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          enter_nxt, exit_nxt, err_nxt, illegal;
    logic [1:0]    code;

    assign code = {a, b};

    always_comb begin
        state_nxt = state;
        lock_nxt  = 1'b0;
        enter_nxt = 1'b0;
        exit_nxt  = 1'b0;
        err_nxt   = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_IDLE: begin
                // lock keeps a held 11 from re-reporting every cycle
                lock_nxt = (code == C_BOTH);
                if (code == C_OUT)                 state_nxt = ST_E1;
                else if (code == C_IN)             state_nxt = ST_X1;
                else if (code == C_BOTH && !lock)  err_nxt   = 1'b1;
            end
            ST_E1: begin
                if (code == C_BOTH)      state_nxt = ST_E2;
                else if (code == C_NONE) state_nxt = ST_IDLE;
                else if (code != C_OUT)  illegal   = 1'b1;
            end
            ST_E2: begin
                if (code == C_IN)        state_nxt = ST_E3;
                else if (code == C_OUT)  state_nxt = ST_E1;
                else if (code != C_BOTH) illegal   = 1'b1;
            end
            ST_E3: begin
                if (code == C_NONE) begin
                    state_nxt = ST_IDLE;
                    enter_nxt = 1'b1;
                end
                else if (code == C_BOTH) state_nxt = ST_E2;
                else if (code != C_IN)   illegal   = 1'b1;
            end
            ST_X1: begin
                if (code == C_BOTH)      state_nxt = ST_X2;
                else if (code == C_NONE) state_nxt = ST_IDLE;
                else if (code != C_IN)   illegal   = 1'b1;
            end
            ST_X2: begin
                if (code == C_OUT)       state_nxt = ST_X3;
                else if (code == C_IN)   state_nxt = ST_X1;
                else if (code != C_BOTH) illegal   = 1'b1;
            end
            ST_X3: begin
                if (code == C_NONE) begin
                    state_nxt = ST_IDLE;
                    exit_nxt  = 1'b1;
                end
                else if (code == C_BOTH) state_nxt = ST_X2;
                else if (code != C_OUT)  illegal   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (illegal) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
        end

        // A legal move always wins over an expiring timer.
        if (TIMEOUT_CYC != 0 && state != ST_IDLE && state_nxt == state
            && tmo_cnt == TMO_LAST) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            lock    <= 1'b0;
            tmo_cnt <= '0;
            enter   <= 1'b0;
            exit    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            lock    <= lock_nxt;
            enter   <= enter_nxt;
            exit    <= exit_nxt;
            seq_err <= err_nxt;
            if (TIMEOUT_CYC == 0 || state == ST_IDLE || state_nxt != state) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-lane parking-lot controller: per-lane direction FSMs feeding a shared
// saturating occupancy counter with full/empty status and loss pulses.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter  int N_LANES     = 2,
    parameter  int CAPACITY    = 100,
    parameter  int TIMEOUT_CYC = 1000000,
    localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    input  logic               clr,
    output logic [N_LANES-1:0] enter,
    output logic [N_LANES-1:0] exit,
    output logic [N_LANES-1:0] seq_err,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               over_err,
    output logic               under_err
);

    localparam int SUM_W = CNT_W + 4;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        parking_lane_fsm #(
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .a       (a[i]),
            .b       (b[i]),
            .enter   (enter[i]),
            .exit    (exit[i]),
            .seq_err (seq_err[i])
        );
    end

    function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] s);
        if (s < 0)          return '0;
        else if (s > CAP_S) return CNT_W'(CAPACITY);
        else                return s[CNT_W-1:0];
    endfunction

    logic [3:0]              n_in, n_out;
    logic signed [SUM_W-1:0] sum;

    // Entries and exits on different lanes net out before clamping.
    always_comb begin
        n_in  = popcount(8'(enter));
        n_out = popcount(8'(exit));
        sum   = $signed({4'b0000, count})
              + $signed({{CNT_W{1'b0}}, n_in})
              - $signed({{CNT_W{1'b0}}, n_out});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            over_err  <= 1'b0;
            under_err <= 1'b0;
        end else if (clr) begin
            count     <= '0;
            over_err  <= 1'b0;
            under_err <= 1'b0;
        end else begin
            count     <= sat_count(sum);
            over_err  <= (sum > CAP_S);
            under_err <= (sum < 0);
        end
    end

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl: a path-table lane model and an
// arithmetic occupancy model predict every output cycle.
module tb_parking_lot_ctrl;

    localparam int N     = 3;
    localparam int CAP   = 3;
    localparam int TMO   = 8;
    localparam int CNT_W = $clog2(CAP + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     a = '0, b = '0;
    logic             clr = 1'b0;
    logic [N-1:0]     en_o, ex_o, er_o;
    logic [CNT_W-1:0] count;
    logic             full, empty, over_err, under_err;

    parking_lot_ctrl #(
        .N_LANES     (N),
        .CAPACITY    (CAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .enter     (en_o),
        .exit      (ex_o),
        .seq_err   (er_o),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .over_err  (over_err),
        .under_err (under_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en, ex, er;
        int cnt;
        int ov, un;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Code sequences of a car passing: index 0 is the idle code 00.
    int path[2][4] = '{'{0, 2, 3, 1}, '{0, 1, 3, 2}};
    int ENT[4] = '{2, 3, 1, 0};
    int EXT[4] = '{1, 3, 2, 0};

    int m_dir[N], m_pos[N], m_dwell[N];
    bit m_lock[N];
    int m_cnt;
    int prev_en, prev_ex;
    int cur[N];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int popc(input int v);
        int n = 0;
        for (int i = 0; i < N; i++) n += (v >> i) & 1;
        return n;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < N; l++) begin
            m_dir[l] = 0; m_pos[l] = 0; m_dwell[l] = 0; m_lock[l] = 0; cur[l] = 0;
        end
        m_cnt = 0; prev_en = 0; prev_ex = 0;
    endtask

    task automatic lane_step(input int l, input int code, output bit e, output bit x, output bit s);
        int p, d, nx;
        e = 0; x = 0; s = 0;
        p = m_pos[l]; d = m_dir[l];
        if (p == 0) begin
            m_dwell[l] = 0;
            if (code == 2)                    begin m_dir[l] = 0; m_pos[l] = 1; end
            else if (code == 1)               begin m_dir[l] = 1; m_pos[l] = 1; end
            else if (code == 3 && !m_lock[l]) s = 1;
            m_lock[l] = (code == 3);
        end else begin
            m_lock[l] = 0;
            nx = (p + 1) % 4;
            if (code == path[d][p]) begin
                if (m_dwell[l] + 1 >= TMO) begin m_pos[l] = 0; s = 1; m_dwell[l] = 0; end
                else m_dwell[l]++;
            end else if (code == path[d][nx]) begin
                m_dwell[l] = 0;
                if (p == 3) begin
                    m_pos[l] = 0;
                    if (d == 0) e = 1; else x = 1;
                end else m_pos[l] = p + 1;
            end else if (code == path[d][p-1]) begin
                m_pos[l] = p - 1; m_dwell[l] = 0;
            end else begin
                m_pos[l] = 0; s = 1; m_dwell[l] = 0;
            end
        end
    endtask

    // Applies cur[]/clr for the coming edge and queues what that edge must produce.
    task automatic drive_and_push(input bit c);
        exp_t ex;
        bit e, x, s;
        int sum;
        ex.en = 0; ex.ex = 0; ex.er = 0;
        for (int l = 0; l < N; l++) begin
            lane_step(l, cur[l], e, x, s);
            ex.en |= int'(e) << l;
            ex.ex |= int'(x) << l;
            ex.er |= int'(s) << l;
            a[l] = cur[l][1];
            b[l] = cur[l][0];
        end
        sum = m_cnt + popc(prev_en) - popc(prev_ex);
        ex.ov = 0; ex.un = 0;
        if (c)              m_cnt = 0;
        else if (sum > CAP) begin m_cnt = CAP; ex.ov = 1; end
        else if (sum < 0)   begin m_cnt = 0;   ex.un = 1; end
        else                m_cnt = sum;
        ex.cnt = m_cnt;
        prev_en = ex.en; prev_ex = ex.ex;
        clr = c;
        exp_q.push_back(ex);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_and_push(1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        a = '0; b = '0; clr = 1'b0;
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        chk("reset_pulses", int'({en_o, ex_o, er_o}), 0);
        chk("reset_errs", int'({over_err, under_err}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_and_push(1'b0);
    endtask

    // Runs a four-step pass on every lane named in the masks, in lock step.
    task automatic pass(input int ent_mask, input int ext_mask);
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < N; l++) begin
                if (ent_mask[l]) cur[l] = ENT[k];
                if (ext_mask[l]) cur[l] = EXT[k];
            end
            tick();
        end
    endtask

    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            chk("enter", int'(en_o), ex.en);
            chk("exit", int'(ex_o), ex.ex);
            chk("seq_err", int'(er_o), ex.er);
            chk("count", int'(count), ex.cnt);
            chk("full", int'(full), int'(ex.cnt == CAP));
            chk("empty", int'(empty), int'(ex.cnt == 0));
            chk("over_err", int'(over_err), ex.ov);
            chk("under_err", int'(under_err), ex.un);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        tick(2);

        pass(1, 0);                      // lane 0 entry
        tick(3);
        chk("entry_count", int'(count), 1);
        chk("entry_empty", int'(empty), 0);

        pass(0, 2);                      // lane 1 exit
        tick(3);
        chk("exit_count", int'(count), 0);
        chk("exit_empty", int'(empty), 1);

        foreach (ENT[k]) begin           // car backs out: 10,11,10,00
            cur[0] = (k == 2) ? 2 : ENT[k];
            tick();
        end
        tick(3);
        chk("backout_count", int'(count), 0);

        cur[0] = 3; tick(4);             // idle sees 11
        cur[0] = 0; tick();
        pass(1, 0);
        tick(2);

        cur[0] = 2; tick(TMO + 2);       // timeout in E1
        cur[0] = 0; tick(3);

        pass(1, 0); pass(1, 0);
        tick(3);
        chk("fill_count", int'(count), 3);
        chk("fill_full", int'(full), 1);
        pass(3, 0);                      // two entries at capacity
        tick(3);
        chk("sat_count", int'(count), 3);
        pass(1, 2);                      // entry and exit net out
        tick(3);
        chk("net_count", int'(count), 3);

        @(negedge clk); drive_and_push(1'b1);  // clr
        tick(2);
        chk("clr_count", int'(count), 0);
        pass(4, 0); pass(4, 0);
        tick(3);

        cur[0] = 2; tick(); cur[0] = 3; tick();
        tick(2);
        do_reset();                      // mid-sequence reset with count 2
        tick(3);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            for (int l = 0; l < N; l++) begin
                int r = $urandom_range(0, 9);
                if (r >= 5 && r <= 8) cur[l] = cur[l] ^ (1 << $urandom_range(0, 1));
                else if (r == 9)      cur[l] = $urandom_range(0, 3);
            end
            @(negedge clk);
            drive_and_push($urandom_range(0, 39) == 0);
        end

        cur = '{default: 0};
        tick(4);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
